// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX/MEM stage bus bundling EX results, dcache request and MEM/WB-side outputs.
interface ex_mem_stage_if #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
);
    logic              ihit;
    logic              dhit;
    logic              flush;
    logic [WORD_W-1:0] ex_aluout;
    logic [WORD_W-1:0] ex_storedata;
    logic [REG_W-1:0]  ex_wsel;
    logic              ex_wen;
    logic              ex_dren;
    logic              ex_dwen;
    logic              ex_memtoreg;
    logic              ex_halt;
    logic [WORD_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic [REG_W-1:0]  emsel;
    logic              emwen;
    logic [WORD_W-1:0] em_aluout;
    logic [WORD_W-1:0] em_loaddata;
    logic              em_memtoreg;
    logic              em_halt;
    logic              mem_busy;
    logic [31:0]       stall_count;

    modport slave (
        input  ihit, dhit, flush, ex_aluout, ex_storedata, ex_wsel, ex_wen, ex_dren, ex_dwen,
               ex_memtoreg, ex_halt, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, emsel, emwen, em_aluout, em_loaddata,
               em_memtoreg, em_halt, mem_busy, stall_count
    );

    modport master (
        output ihit, dhit, flush, ex_aluout, ex_storedata, ex_wsel, ex_wen, ex_dren, ex_dwen,
               ex_memtoreg, ex_halt, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, emsel, emwen, em_aluout, em_loaddata,
               em_memtoreg, em_halt, mem_busy, stall_count
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM latch plus dcache request sequencer; stalls via mem_busy until dhit.
// Define EM_STALL_CNT_EN to build the saturating stall_count counter (tied to 0 otherwise).
module ex_mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic          CLK,
    input  logic          nRST,
    ex_mem_stage_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [REG_W-1:0]  wsel;
    logic              wen;
    logic              dren;
    logic              dwen;
    logic              memtoreg;
    logic              halt;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] storedata;
    logic [WORD_W-1:0] loaddata;
    logic              req_hit;
    logic              advance;
    logic              bubble;

    assign req_hit      = state == REQ && bus.dhit;
    assign bus.mem_busy = state == REQ && !bus.dhit;
    assign advance      = bus.ihit && !bus.mem_busy;
    // once halted, every later advance is a bubble so no further dcache traffic is issued
    assign bubble       = bus.flush || halt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wsel      <= '0;
            wen       <= 1'b0;
            dren      <= 1'b0;
            dwen      <= 1'b0;
            memtoreg  <= 1'b0;
            halt      <= 1'b0;
            aluout    <= '0;
            storedata <= '0;
            loaddata  <= '0;
        end else begin
            if (advance) begin
                wsel      <= bubble ? '0 : bus.ex_wsel;
                wen       <= !bubble && bus.ex_wen;
                dren      <= !bubble && bus.ex_dren;
                dwen      <= !bubble && bus.ex_dwen;
                memtoreg  <= !bubble && bus.ex_memtoreg;
                aluout    <= bubble ? '0 : bus.ex_aluout;
                storedata <= bubble ? '0 : bus.ex_storedata;
                halt      <= halt || (!bus.flush && bus.ex_halt);
                state     <= (!bubble && (bus.ex_dren || bus.ex_dwen)) ? REQ : IDLE;
            end else if (req_hit) begin
                state <= DONE;
            end
            if (req_hit && dren && !dwen)
                loaddata <= bus.dmemload;
        end
    end

    // a store wins over a simultaneous load request
    assign bus.dmemREN     = state == REQ && dren && !dwen;
    assign bus.dmemWEN     = state == REQ && dwen;
    assign bus.dmemaddr    = aluout;
    assign bus.dmemstore   = storedata;
    assign bus.emsel       = wsel;
    assign bus.emwen       = wen && (wsel != '0);
    assign bus.em_aluout   = aluout;
    assign bus.em_loaddata = loaddata;
    assign bus.em_memtoreg = memtoreg;
    assign bus.em_halt     = halt;

`ifdef EM_STALL_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (bus.mem_busy && cnt != '1)
            cnt <= cnt + 32'd1;
    end

    assign bus.stall_count = cnt;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: table-driven directed vectors for ex_mem_stage plus hand sequences for
// reset, dual request and asynchronous reset during an outstanding request.
module tb_ex_mem_stage;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic ih, dh, fl;
        logic [4:0] ws;
        logic we, dr, dw, mr, ht;
        logic [31:0] alu, sd, ld;
        logic [4:0] e_sel;
        logic e_wen;
        logic [31:0] e_alu, e_sd;
        logic e_mr, e_ren, e_wwen, e_busy;
        logic [31:0] e_ld;
        logic e_halt;
        logic [31:0] e_sc;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string n, input int r, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s row %0d got %h want %h", n, r, a, e);
        end
    endtask

    function automatic logic [31:0] sc_exp(input logic [31:0] s);
`ifdef EM_STALL_CNT_EN
        return s;
`else
        return (s & 32'd0);
`endif
    endfunction

    task automatic drive(input vec_t x);
        bus.ihit = x.ih;
        bus.dhit = x.dh;
        bus.flush = x.fl;
        bus.ex_wsel = x.ws;
        bus.ex_wen = x.we;
        bus.ex_dren = x.dr;
        bus.ex_dwen = x.dw;
        bus.ex_memtoreg = x.mr;
        bus.ex_halt = x.ht;
        bus.ex_aluout = x.alu;
        bus.ex_storedata = x.sd;
        bus.dmemload = x.ld;
    endtask

    task automatic check_all(input string n, input int r);
        chk({n, ":emsel"}, r, 32'(bus.emsel), 32'd0);
        chk({n, ":emwen"}, r, 32'(bus.emwen), 32'd0);
        chk({n, ":aluout"}, r, bus.em_aluout, 32'd0);
        chk({n, ":ren"}, r, 32'(bus.dmemREN), 32'd0);
        chk({n, ":wen"}, r, 32'(bus.dmemWEN), 32'd0);
        chk({n, ":busy"}, r, 32'(bus.mem_busy), 32'd0);
        chk({n, ":halt"}, r, 32'(bus.em_halt), 32'd0);
        chk({n, ":loaddata"}, r, bus.em_loaddata, 32'd0);
        chk({n, ":stall"}, r, bus.stall_count, 32'd0);
    endtask

    initial begin
        vec_t z;
        z = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0};
        drive(z);
        //      ih dh fl ws we dr dw mr ht alu          sd       ld             sel wen alu    sd       mr ren wwen busy ld            halt sc
        v[0]  = '{1,0,0,5,1,0,0,0,0,32'h10,0,0,            5,1,32'h10,0,        0,0,0,0,0,            0,0};
        v[1]  = '{1,0,0,8,1,1,0,1,0,32'h80,0,0,            8,1,32'h80,0,        1,1,0,1,0,            0,0};
        v[2]  = '{1,0,0,9,1,0,0,0,0,32'h99,0,0,            8,1,32'h80,0,        1,1,0,1,0,            0,1};
        v[3]  = '{1,0,0,9,1,0,0,0,0,32'h99,0,0,            8,1,32'h80,0,        1,1,0,1,0,            0,2};
        v[4]  = '{1,0,0,9,1,0,0,0,0,32'h99,0,0,            8,1,32'h80,0,        1,1,0,1,0,            0,3};
        v[5]  = '{1,1,0,9,1,0,0,0,0,32'h99,0,32'hDEADBEEF, 9,1,32'h99,0,        0,0,0,0,32'hDEADBEEF, 0,3};
        v[6]  = '{1,0,0,0,0,0,1,0,0,32'h40,32'h1234,0,     0,0,32'h40,32'h1234, 0,0,1,1,32'hDEADBEEF, 0,3};
        v[7]  = '{0,1,0,0,0,0,0,0,0,0,0,0,                 0,0,32'h40,32'h1234, 0,0,0,0,32'hDEADBEEF, 0,3};
        v[8]  = '{0,0,0,0,0,0,0,0,0,0,0,0,                 0,0,32'h40,32'h1234, 0,0,0,0,32'hDEADBEEF, 0,3};
        v[9]  = '{1,0,1,7,1,1,0,0,0,32'h55,0,0,            0,0,0,0,             0,0,0,0,32'hDEADBEEF, 0,3};
        v[10] = '{1,0,0,0,1,0,0,0,0,32'h20,0,0,            0,0,32'h20,0,        0,0,0,0,32'hDEADBEEF, 0,3};
        v[11] = '{0,0,1,3,1,0,0,0,0,0,0,0,                 0,0,32'h20,0,        0,0,0,0,32'hDEADBEEF, 0,3};
        v[12] = '{1,0,0,4,1,0,0,0,1,32'h30,0,0,            4,1,32'h30,0,        0,0,0,0,32'hDEADBEEF, 1,3};
        v[13] = '{1,0,1,0,0,0,0,0,0,0,0,0,                 0,0,0,0,             0,0,0,0,32'hDEADBEEF, 1,3};
        v[14] = '{1,0,0,6,1,1,0,0,0,32'h70,0,0,            0,0,0,0,             0,0,0,0,32'hDEADBEEF, 1,3};

        repeat (2) @(posedge CLK);
        #1 check_all("reset", -1);
        @(negedge CLK) nRST = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK) drive(v[i]);
            @(posedge CLK);
            #1;
            chk("emsel", i, 32'(bus.emsel), 32'(v[i].e_sel));
            chk("emwen", i, 32'(bus.emwen), 32'(v[i].e_wen));
            chk("em_aluout", i, bus.em_aluout, v[i].e_alu);
            chk("dmemaddr", i, bus.dmemaddr, v[i].e_alu);
            chk("dmemstore", i, bus.dmemstore, v[i].e_sd);
            chk("em_memtoreg", i, 32'(bus.em_memtoreg), 32'(v[i].e_mr));
            chk("dmemREN", i, 32'(bus.dmemREN), 32'(v[i].e_ren));
            chk("dmemWEN", i, 32'(bus.dmemWEN), 32'(v[i].e_wwen));
            chk("mem_busy", i, 32'(bus.mem_busy), 32'(v[i].e_busy));
            chk("em_loaddata", i, bus.em_loaddata, v[i].e_ld);
            chk("em_halt", i, 32'(bus.em_halt), 32'(v[i].e_halt));
            chk("stall_count", i, bus.stall_count, sc_exp(v[i].e_sc));
        end

        // asynchronous reset clears the sticky halt without a clock edge
        @(negedge CLK) drive(z);
        nRST = 1'b0;
        #1 check_all("rst2", 100);
        @(negedge CLK) nRST = 1'b1;

        // load and store both set: store wins, load data never captured
        @(negedge CLK) begin
            z.ih = 1; z.dr = 1; z.dw = 1; z.alu = 32'h60; z.ld = 32'hCAFEF00D;
            drive(z);
        end
        @(posedge CLK);
        #1;
        chk("dual:ren", 101, 32'(bus.dmemREN), 32'd0);
        chk("dual:wen", 101, 32'(bus.dmemWEN), 32'd1);
        chk("dual:busy", 101, 32'(bus.mem_busy), 32'd1);
        @(negedge CLK) begin
            z = '{0,1,0,0,0,0,0,0,0,0,0,32'hCAFEF00D, 0,0,0,0,0,0,0,0,0,0,0};
            drive(z);
        end
        @(posedge CLK);
        #1;
        chk("dual:loaddata", 102, bus.em_loaddata, 32'd0);
        chk("dual:done_wen", 102, 32'(bus.dmemWEN), 32'd0);

        // halting load enters REQ, then reset mid-request drops it immediately
        @(negedge CLK) begin
            z = '{1,0,0,2,1,1,0,1,1,32'h44,0,0, 0,0,0,0,0,0,0,0,0,0,0};
            drive(z);
        end
        @(posedge CLK);
        #1;
        chk("hreq:ren", 103, 32'(bus.dmemREN), 32'd1);
        chk("hreq:halt", 103, 32'(bus.em_halt), 32'd1);
        chk("hreq:busy", 103, 32'(bus.mem_busy), 32'd1);
        @(negedge CLK) begin
            z.ih = 0; z.fl = 1;
            drive(z);
        end
        #2 nRST = 1'b0;
        #1;
        chk("arst:ren", 104, 32'(bus.dmemREN), 32'd0);
        chk("arst:halt", 104, 32'(bus.em_halt), 32'd0);
        chk("arst:busy", 104, 32'(bus.mem_busy), 32'd0);
        chk("arst:aluout", 104, bus.em_aluout, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
